// File: rtl/memory_bank_mio.sv
// memory_bank_mio: word-addressed register file with NUM_IO memory-mapped IO channels at the top of the map.
// All architectural state lives in one flat vector that doubles as the scan chain.
module memory_bank_mio #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_IO = 2,
    parameter logic [NUM_IO-1:0] EDGE_MODE = 2'b01
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             write_enable,
    input  logic                             read_enable,
    output logic [DATA_WIDTH-1:0]            data_out,
    input  logic                             scan_enable,
    input  logic                             scan_in,
    output logic                             scan_out,
    input  logic [NUM_IO-1:0]                io_in,
    output logic [NUM_IO*(DATA_WIDTH-1)-1:0] io_out
);
    localparam int MEM_SIZE = 2**ADDR_WIDTH - NUM_IO;
    localparam int OW = DATA_WIDTH - 1;
    localparam int IO_BASE = MEM_SIZE * DATA_WIDTH;
    localparam int L = (MEM_SIZE + NUM_IO) * DATA_WIDTH;

    // Chain order: mem[0..] then per channel {edge_flag, out_reg}, bit 0 nearest scan_in
    logic [L-1:0] state;
    logic [NUM_IO-1:0] sync1, sync2, prev, edge_flag, sel, in_bit, rise;

    for (genvar k = 0; k < NUM_IO; k++) begin : g_io
        assign io_out[k*OW +: OW] = state[IO_BASE + k*DATA_WIDTH +: OW];
        assign edge_flag[k] = state[IO_BASE + k*DATA_WIDTH + OW];
        assign sel[k] = address == ADDR_WIDTH'(MEM_SIZE + k);
        assign in_bit[k] = EDGE_MODE[k] ? edge_flag[k] : sync2[k];
    end

    assign rise = sync2 & ~prev;
    assign scan_out = state[L-1];

    always_comb begin
        data_out = state[int'(address)*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 0; k < NUM_IO; k++)
            if (sel[k]) data_out = {state[IO_BASE + k*DATA_WIDTH +: OW], in_bit[k]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '0;
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (scan_enable) begin
                state <= {state[L-2:0], scan_in};
            end else begin
                if (write_enable && address < ADDR_WIDTH'(MEM_SIZE))
                    state[int'(address)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                for (int k = 0; k < NUM_IO; k++) begin
                    if (write_enable && sel[k])
                        state[IO_BASE + k*DATA_WIDTH +: OW] <= data_in[DATA_WIDTH-1:1];
                    // a new edge in the clearing cycle wins so it is never lost
                    if (rise[k])
                        state[IO_BASE + k*DATA_WIDTH + OW] <= 1'b1;
                    else if ((read_enable || write_enable) && sel[k])
                        state[IO_BASE + k*DATA_WIDTH + OW] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/memory_bank_mio.md
Name: memory_bank_mio

Overview:
- Parametrised successor to the single-IO scan-chain memory bank. It provides a word-addressed register file plus NUM_IO memory-mapped IO channels at the top of the address space.
- Each IO channel has a writable output register and a synchronised input bit. The input bit is readable as a level or as a sticky rising-edge flag.
- All architectural state sits on one scan chain for load/dump.
- Sits between the CPU core's memory port and the chip pins.

Parameters:
- ADDR_WIDTH, 5: address bits; total address space is 2**ADDR_WIDTH.
- DATA_WIDTH, 8: word width, minimum 2.
- NUM_IO, 2: number of IO channels, 1 to 2**ADDR_WIDTH-1.
- EDGE_MODE, 2'b01: NUM_IO-bit mask. Bit k=1 makes channel k's input read as a sticky rising-edge flag; 0 makes it read as a level.
- MEM_SIZE (derived, not overridable): 2**ADDR_WIDTH - NUM_IO.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- address  in  ADDR_WIDTH  word address
- data_in  in  DATA_WIDTH  write data
- write_enable  in  1  write strobe
- read_enable  in  1  read strobe; clears an IO edge flag
- data_out  out  DATA_WIDTH  combinational read data
- scan_enable  in  1  scan shift mode
- scan_in  in  1  scan chain input
- scan_out  out  1  scan chain output
- io_in  in  NUM_IO  asynchronous pin inputs
- io_out  out  NUM_IO*(DATA_WIDTH-1)  channel k output = bits [k*(DATA_WIDTH-1) +: DATA_WIDTH-1]

Behaviour:
- Address map:
  - 0..MEM_SIZE-1: memory words mem[a].
  - MEM_SIZE+k: IO channel k.
- Reset (rst=0, asynchronous): all of the following clear to 0, so io_out=0 and scan_out=0 during and after reset:
  - mem words, out_reg[k], edge_flag[k];
  - sync1[k], sync2[k], prev[k].
- Reset is released synchronously by the external sync. Reset mid-scan or mid-write discards that operation.
- Write (scan_enable=0, write_enable=1), at the clock edge:
  - Memory address: mem[address] <= data_in.
  - IO address: out_reg[k] <= data_in[DATA_WIDTH-1:1]; data_in[0] is ignored.
  - A write to IO address k also clears edge_flag[k].
- Read (combinational):
  - Memory address: data_out = mem[address].
  - IO address: data_out = {out_reg[k], in_bit[k]}, where in_bit[k] = edge_flag[k] if EDGE_MODE[k], else sync2[k].
  - Every address decodes; data_out is never X after reset.
- Input path per channel, every cycle including during scan:
  - sync1 <= io_in[k]; sync2 <= sync1; prev <= sync2.
  - A pin rise before edge N reads as level 1 after edge N+1. The edge flag is 1 after edge N+2.
- Edge flag, evaluated only when scan_enable=0:
  - Set condition: sync2 & ~prev.
  - Clear condition: (read_enable | write_enable) with address == MEM_SIZE+k.
  - Set and clear in the same cycle: set wins, so no edge is lost.
  - The flag holds until cleared; multiple edges collapse to 1.
  - In level-mode channels the flag still runs but is not visible.
- Scan (scan_enable=1): has priority over write_enable and read_enable. No writes occur and no flag set/clear occurs.
  - Chain order: scan_in -> mem[0] -> mem[1] -> ... -> mem[MEM_SIZE-1] -> out_reg[0] -> edge_flag[0] -> ... -> out_reg[NUM_IO-1] -> edge_flag[NUM_IO-1] -> scan_out.
  - Within each register: bit0 <= upstream serial input; bit i <= bit i-1; the MSB feeds downstream.
  - Chain length L = NUM_IO*DATA_WIDTH + MEM_SIZE*DATA_WIDTH, which is 256 at the defaults.
  - Synchronisers are excluded from the chain.
  - scan_out = MSB of edge_flag[NUM_IO-1], a 1-bit register. It is registered, so no combinational path from scan_in.
- io_out is driven directly from out_reg and changes the cycle after a write or scan shift.

Test Plan (defaults: MEM_SIZE=30, IO at addresses 30 and 31):
- Reset/map:
  - Stimulus: rst=0, release; write mem[0]=8'hA5, mem[29]=8'h3C, then read both.
  - Response: A5 and 3C; reading address 31 before any write gives 8'h00; io_out=14'h0.
- IO output:
  - Stimulus: write addr 30 = 8'hFF, addr 31 = 8'h82.
  - Response: io_out[6:0]=7'h7F, io_out[13:7]=7'h41; read 30 = 8'hFE with io_in=0.
- Level input:
  - Stimulus: io_in[1] 0->1 just after edge 0.
  - Response: data_out[0] at addr 31 is 0 after edge 1 and 1 after edge 2.
- Edge flag:
  - Stimulus: io_in[0] pulses high 4 cycles, then low.
  - Response: addr 30 bit0 = 1 from 3 edges after the rise and stays 1 after io_in falls. read_enable at addr 30 clears it on the next edge.
  - Stimulus: repeat with a new edge coinciding with the clear cycle.
  - Response: flag stays 1.
- Scan:
  - Stimulus: scan_enable=1, shift 256 bits of pattern P into scan_in.
  - Response: scan_out replays the pre-scan contents of the chain. Afterward mem/IO reads match P mapped by chain order; write_enable asserted during the shift has no effect.
- Async reset mid-scan:
  - Stimulus: drop rst for half a cycle during a shift.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
